// File: rtl/abc2dq0_shared_pkg.sv
// abc2dq0_shared_pkg: shared definitions for the resource-shared Park transform.
//   single_t / ADD / SUB / ENA_MATH : operand type and Adder_nodsp/IP control codes
//   K_1_3, K_INV_SQRT3               : scaling constants (IEEE-754 single)
//   state_t                          : FSM encodings ABC2DQ0_S_IDLE..ABC2DQ0_S_DONE
//   fp_mul / fp_add                  : behavioural single-precision ops used by the IPs
// Zero/denormal operands are treated as zero; rounding is round-to-nearest-even.
package abc2dq0_shared_pkg;
  typedef logic [31:0] single_t;

  localparam logic    ADD         = 1'b0;
  localparam logic    SUB         = 1'b1;
  localparam logic    ENA_MATH    = 1'b1;
  localparam single_t K_1_3       = 32'h3EAAAAAB;
  localparam single_t K_INV_SQRT3 = 32'h3F13CD3A;

  typedef enum logic [2:0] {
    ABC2DQ0_S_IDLE, ABC2DQ0_S_1, ABC2DQ0_S_2, ABC2DQ0_S_3,
    ABC2DQ0_S_4, ABC2DQ0_S_5, ABC2DQ0_S_6, ABC2DQ0_S_DONE
  } state_t;

  function automatic logic is_inf_nan(input single_t x);
    return x[30:23] == 8'hFF;
  endfunction

  // Round a 24-bit significand (hidden bit at [23]) with guard/sticky and pack.
  function automatic single_t fp_pack(input logic s, input int e, input logic [23:0] m,
                                      input logic g, input logic st);
    logic [24:0] r;
    int er;
    r  = {1'b0, m} + {24'd0, g & (st | m[0])};
    er = r[24] ? e + 1 : e;
    if (er <= 0)   return {s, 31'd0};
    if (er >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(er), r[24] ? r[23:1] : r[22:0]};
  endfunction

  function automatic single_t fp_mul(input single_t a, input single_t b);
    logic s;
    logic [47:0] p;
    int e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return fp_pack(s, e + 1, p[47:24], p[23], |p[22:0]);
    return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic single_t fp_add(input single_t a, input single_t b, input logic sub);
    single_t bb, x, y;
    logic [23:0] mx, my;
    logic [49:0] xe, ye;
    logic [50:0] sum, norm;
    int diff, pos;
    bb = {b[31] ^ sub, b[30:0]};
    if (a[30:0] >= bb[30:0]) begin x = a; y = bb; end
    else begin x = bb; y = a; end
    mx   = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my   = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    diff = int'(x[30:23]) - int'(y[30:23]);
    xe   = {mx, 26'd0};
    // Far-away operand only contributes to the sticky bit.
    ye   = (diff > 26) ? {49'd0, |my} : ({my, 26'd0} >> diff);
    sum  = (x[31] == y[31]) ? {1'b0, xe} + {1'b0, ye} : {1'b0, xe} - {1'b0, ye};
    if (sum == 51'd0) return 32'd0;
    pos = 0;
    for (int i = 0; i < 51; i++) if (sum[i]) pos = i;
    norm = sum << (50 - pos);
    return fp_pack(x[31], int'(x[30:23]) + pos - 49, norm[50:27], norm[26], |norm[25:0]);
  endfunction
endpackage

// File: rtl/Adder_nodsp.sv
// Adder_nodsp: fabric single-precision adder/subtractor, fixed LAT-cycle pipeline.
//   clk, clk_en : clock and pipeline advance enable
//   add_sub     : ADD (a+b) or SUB (a-b)
//   a, b        : operands; result LAT cycles after issue
module Adder_nodsp import abc2dq0_shared_pkg::*; #(
  parameter int LAT = 7
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        add_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [LAT-1:0][31:0] dat_pipe;

  always_ff @(posedge clk)
    if (clk_en) begin
      dat_pipe[0] <= fp_add(a, b, add_sub);
      for (int i = 1; i < LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

  assign result = dat_pipe[LAT-1];
endmodule

// File: rtl/Multiplier_nodsp.sv
// Multiplier_nodsp: fabric single-precision multiplier, fixed LAT-cycle pipeline.
//   clk, clk_en : clock and pipeline advance enable
//   a, b        : operands; result = a*b, LAT cycles after issue
module Multiplier_nodsp import abc2dq0_shared_pkg::*; #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [LAT-1:0][31:0] dat_pipe;

  always_ff @(posedge clk)
    if (clk_en) begin
      dat_pipe[0] <= fp_mul(a, b);
      for (int i = 1; i < LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

  assign result = dat_pipe[LAT-1];
endmodule

// File: rtl/abc2dq0_shared.sv
// abc2dq0_shared: single-precision abc -> dq0 (Park) transform sharing one
// Multiplier_nodsp and one Adder_nodsp under an FSM.
//   clk, rst (sync, active high)
//   sta                      : start; Va/Vb/Vc/sin_theta/cos_theta sampled same cycle
//   Vd, Vq, V0               : results, held until the next done_sig
//   busy                     : cycle after accepted sta through done cycle
//   err                      : Inf/NaN input flag, valid with done_sig
//   done_sig                 : one-cycle pulse with new results
// Optional: ABC2DQ0_NAN_GUARD_EN enables the Inf/NaN short-cut (done next cycle,
// err=1, outputs 0). Without it err is tied low.
module abc2dq0_shared import abc2dq0_shared_pkg::*; #(
  parameter int MUL_LAT = 5,
  parameter int ADD_LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sta,
  input  logic [31:0] Va,
  input  logic [31:0] Vb,
  input  logic [31:0] Vc,
  input  logic [31:0] sin_theta,
  input  logic [31:0] cos_theta,
  output logic [31:0] Vd,
  output logic [31:0] Vq,
  output logic [31:0] V0,
  output logic        busy,
  output logic        err,
  output logic        done_sig
);
  localparam int M = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam logic [4:0] C_ADD = 5'(ADD_LAT);
  localparam logic [4:0] C_MUL = 5'(MUL_LAT);
  localparam logic [4:0] C_M   = 5'(M);
  localparam logic [4:0] C_S5L = 5'(MUL_LAT + 3);
  localparam logic [4:0] C_S6L = 5'(ADD_LAT + 1);

  state_t      state;
  logic [4:0]  cnt;
  logic        last;
  single_t     r_va, r_vb, r_vc, r_sin, r_cos;
  single_t     r_t, r_d, r_v0, r_alpha, r_beta, r_vd;
  logic [3:0][31:0] p;
  single_t     mul_a, mul_b, add_a, add_b, mul_res, add_res;
  logic        add_op;

  Multiplier_nodsp #(.LAT(MUL_LAT)) u_mul (
    .clk(clk), .clk_en(ENA_MATH), .a(mul_a), .b(mul_b), .result(mul_res));
  Adder_nodsp #(.LAT(ADD_LAT)) u_add (
    .clk(clk), .clk_en(ENA_MATH), .add_sub(add_op), .a(add_a), .b(add_b), .result(add_res));

  // Operand muxes: operands depend only on state/cnt and registers that are
  // stable for the whole step, so each op's inputs stay put until capture.
  always_comb begin
    mul_a = '0; mul_b = '0; add_a = '0; add_b = '0; add_op = ADD;
    case (state)
      ABC2DQ0_S_1: begin add_a = r_vb; add_b = r_vc; end
      ABC2DQ0_S_2: begin add_a = r_va; add_b = r_t; end
      ABC2DQ0_S_3: begin add_a = r_vb; add_b = r_vc; add_op = SUB; mul_a = r_t; mul_b = K_1_3; end
      ABC2DQ0_S_4: begin add_a = r_va; add_b = r_v0; add_op = SUB; mul_a = r_d; mul_b = K_INV_SQRT3; end
      ABC2DQ0_S_5:
        case (cnt)
          5'd0:    begin mul_a = r_alpha; mul_b = r_sin; end
          5'd1:    begin mul_a = r_beta;  mul_b = r_cos; end
          5'd2:    begin mul_a = r_alpha; mul_b = r_cos; end
          default: begin mul_a = r_beta;  mul_b = r_sin; end
        endcase
      ABC2DQ0_S_6: begin
        add_a  = (cnt == 5'd0) ? p[0] : p[2];
        add_b  = (cnt == 5'd0) ? p[1] : p[3];
        add_op = (cnt == 5'd0) ? SUB : ADD;
      end
      default: ;
    endcase
  end

  always_comb begin
    last = 1'b1;
    case (state)
      ABC2DQ0_S_1, ABC2DQ0_S_2: last = (cnt == C_ADD);
      ABC2DQ0_S_3, ABC2DQ0_S_4: last = (cnt == C_M);
      ABC2DQ0_S_5:              last = (cnt == C_S5L);
      ABC2DQ0_S_6:              last = (cnt == C_S6L);
      default: ;
    endcase
  end

`ifdef ABC2DQ0_NAN_GUARD_EN
  logic err_q;
  logic bad_in;
  assign err    = err_q;
  assign bad_in = is_inf_nan(Va) | is_inf_nan(Vb) | is_inf_nan(Vc) |
                  is_inf_nan(sin_theta) | is_inf_nan(cos_theta);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ABC2DQ0_S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done_sig <= 1'b0;
      Vd       <= '0;
      Vq       <= '0;
      V0       <= '0;
`ifdef ABC2DQ0_NAN_GUARD_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_sig <= 1'b0;
      if (state != ABC2DQ0_S_IDLE && state != ABC2DQ0_S_DONE)
        cnt <= last ? 5'd0 : cnt + 5'd1;
      case (state)
        ABC2DQ0_S_IDLE:
          if (sta) begin
            r_va <= Va; r_vb <= Vb; r_vc <= Vc; r_sin <= sin_theta; r_cos <= cos_theta;
            busy <= 1'b1;
            cnt  <= '0;
`ifdef ABC2DQ0_NAN_GUARD_EN
            if (bad_in) begin
              state    <= ABC2DQ0_S_DONE;
              done_sig <= 1'b1;
              err_q    <= 1'b1;
              Vd <= '0; Vq <= '0; V0 <= '0;
            end else
              state <= ABC2DQ0_S_1;
`else
            state <= ABC2DQ0_S_1;
`endif
          end
        ABC2DQ0_S_1: if (last) begin r_t <= add_res; state <= ABC2DQ0_S_2; end
        ABC2DQ0_S_2: if (last) begin r_t <= add_res; state <= ABC2DQ0_S_3; end
        ABC2DQ0_S_3: begin
          if (cnt == C_ADD) r_d  <= add_res;
          if (cnt == C_MUL) r_v0 <= mul_res;
          if (last) state <= ABC2DQ0_S_4;
        end
        ABC2DQ0_S_4: begin
          if (cnt == C_ADD) r_alpha <= add_res;
          if (cnt == C_MUL) r_beta  <= mul_res;
          if (last) state <= ABC2DQ0_S_5;
        end
        ABC2DQ0_S_5: begin
          // Burst results arrive back-to-back, one per cycle.
          if (cnt >= C_MUL) p[2'(cnt - C_MUL)] <= mul_res;
          if (last) state <= ABC2DQ0_S_6;
        end
        ABC2DQ0_S_6: begin
          if (cnt == C_ADD) r_vd <= add_res;
          if (last) begin
            Vd <= r_vd; Vq <= add_res; V0 <= r_v0;
            done_sig <= 1'b1;
`ifdef ABC2DQ0_NAN_GUARD_EN
            err_q <= 1'b0;
`endif
            state <= ABC2DQ0_S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ABC2DQ0_S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/abc2dq0_shared.md
# abc2dq0_shared

Resource-shared single-precision Park transform for the PV control datapath: converts sampled three-phase quantities Va/Vb/Vc plus sin_theta/cos_theta into Vd, Vq, V0. It is the measurement-side counterpart of the dq0-to-abc modulator path. One Multiplier_nodsp and one Adder_nodsp are time-multiplexed under an FSM, trading latency for area. It sits between the ADC/phase-sampling stage and the dq current/voltage controllers.

## Interface
- MUL_LAT, 5: fixed pipeline latency of Multiplier_nodsp, in cycles.
- ADD_LAT, 7: fixed pipeline latency of Adder_nodsp, in cycles.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sta  in  1  start pulse; inputs are sampled in the same cycle.
- Va, Vb, Vc  in  `SINGLE  phase quantities, IEEE-754 single.
- sin_theta, cos_theta  in  `SINGLE  angle terms for the same sample.
- Vd, Vq, V0  out  `SINGLE  results; registered and held until the next done_sig.
- busy  out  1  high from the cycle after sta is accepted through the done cycle.
- err  out  1  invalid-input flag; valid with done_sig.
- done_sig  out  1  one-cycle pulse marking new Vd/Vq/V0/err.

## Operation
- Math (amplitude-invariant, matching the team's convention Va = Vd·sinθ + Vq·cosθ):
  - V0 = (Va+Vb+Vc)·(1/3)
  - α = Va − V0
  - β = (Vb−Vc)·(1/√3)
  - Vd = α·sinθ − β·cosθ
  - Vq = α·cosθ + β·sinθ
- IDLE: when sta=1 and rst=0, latch all five inputs into operand registers and go to S1. sta is ignored in every other state.
- Every step issues its ops at dwell counter 0 and holds operands stable until captured. Results are captured at counter = latency, and the step exits on its last capture. M = max(ADD_LAT, MUL_LAT).
  - S1: add s1 = Vb+Vc. Dwell ADD_LAT+1.
  - S2: add s2 = Va+s1. Dwell ADD_LAT+1.
  - S3: sub d = Vb−Vc; mul V0 = s2·K_1_3. Dwell M+1.
  - S4: sub α = Va−V0; mul β = d·K_INV_SQRT3. Dwell M+1.
  - S5: mul burst, one op per cycle at cnt 0..3: α·sin, β·cos, α·cos, β·sin. Captured at cnt MUL_LAT..MUL_LAT+3. Dwell MUL_LAT+4.
  - S6: sub Vd = p0−p1 at cnt 0; add Vq = p2+p3 at cnt 1. Dwell ADD_LAT+2.
  - DONE: update output registers, pulse done_sig, then return to IDLE.
- Constants: K_1_3 = 32'h3EAAAAAB, K_INV_SQRT3 = 32'h3F13CD3A.
- IP clk_en is tied to `ena_math; IP add_sub is driven with `add/`sub.
- Reset, including mid-operation:
  - FSM returns to IDLE and the counter clears.
  - Vd, Vq, V0 = 0; busy, err, done_sig = 0.
  - sta coincident with rst is ignored.
  - In-flight IP results are never captured, because the FSM gates all captures by state.

## Timing
- With sta in cycle 0, done_sig is high in cycle 1 + 2(ADD_LAT+1) + 2(M+1) + (MUL_LAT+4) + (ADD_LAT+2) = 51 at default parameters.
- Latency is fixed and independent of data.
- busy is high in cycles 1..51. sta may be reasserted in cycle 52 at the earliest; a sta in cycle 51 (DONE) is ignored.
- Throughput: one transform per 52 cycles.
- Outputs change only in the done cycle and are stable otherwise.

## Configuration
- ABC2DQ0_NAN_GUARD_EN defined:
  - In the sta cycle, if any input has exponent 8'hFF (Inf/NaN), skip S1–S6.
  - Next cycle is DONE: done_sig = 1 in cycle 1, err = 1, and Vd/Vq/V0 = 0.
  - Valid inputs keep the normal 51-cycle latency with err = 0.
- Undefined: no check is made; err is tied to 0 and the normal latency always applies.

## Structure
- Shared global parameter include holds:
  - `SINGLE, `add/`sub, `ena_math (already present);
  - new K_1_3 and K_INV_SQRT3;
  - the state encodings ABC2DQ0_S_IDLE..ABC2DQ0_S_DONE.
- Single module: FSM, dwell counter, operand muxes and capture registers. Instantiates exactly one Multiplier_nodsp and one Adder_nodsp; no further sub-module.

## Test plan
- θ=90° (sin=32'h3F800000, cos=0), Va=1.0, Vb=Vc=−0.5 (32'hBF000000), sta in cycle 0 -> done_sig only in cycle 51; Vd=1.0, Vq=0, V0=0, within 2 ulp or |e|<1e-6.
- θ=0 (sin=0, cos=1.0), Va=0, Vb=32'hBF5DB3D7, Vc=32'h3F5DB3D7 -> Vd≈1.0, Vq≈0, V0≈0, with |e|<1e-6.
- Va=Vb=Vc=2.0 at any θ -> V0≈2.0, Vd≈0, Vq≈0.
- sta again in cycles 10 and 51 -> single done at 51; next sta at cycle 52 -> done at 103 with the new data.
- rst in cycle 20 -> no done_sig; all outputs 0 and busy 0 from cycle 21; a new sta afterwards gives done 51 cycles later.
- ABC2DQ0_NAN_GUARD_EN defined, Va=32'h7FC00000 -> done_sig and err in cycle 1, outputs 0. Undefined -> done at 51 with err=0.
